// File: rtl/olink_pkg.sv
// ============================================================================
// Module  : olink_pkg
// Purpose : Shared state encoding, default parameters and status-word layout
//           for the optical link bring-up controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package olink_pkg;

    localparam int DEF_RST_PULSE = 16;
    localparam int DEF_TMO_W     = 20;
    localparam int DEF_COMMA_REQ = 8;
    localparam int DEF_BAD_LIMIT = 4;
    localparam int DEF_MAX_RETRY = 15;

    // FAIL shares the external code 7 with UP; bit 3 is what separates them.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WAIT_PLL = 4'd1,
        ST_TX_RST   = 4'd2,
        ST_WAIT_TX  = 4'd3,
        ST_RX_RST   = 4'd4,
        ST_WAIT_RX  = 4'd5,
        ST_ALIGN    = 4'd6,
        ST_UP       = 4'd7,
        ST_FAIL     = 4'd15
    } olink_state_e;

    localparam int STAT_STATE_LSB   = 0;
    localparam int STAT_STATE_W     = 3;
    localparam int STAT_RETRY_LSB   = 3;
    localparam int STAT_RETRY_W     = 4;
    localparam int STAT_LINK_UP_BIT = 7;
    localparam int STAT_FAIL_BIT    = 8;
    localparam int STAT_W           = 9;

    function automatic logic [STAT_W-1:0] pack_status(
        input logic [STAT_STATE_W-1:0] st,
        input logic [STAT_RETRY_W-1:0] retry,
        input logic                    up,
        input logic                    fl
    );
        logic [STAT_W-1:0] w;
        w = '0;
        w[STAT_STATE_LSB +: STAT_STATE_W] = st;
        w[STAT_RETRY_LSB +: STAT_RETRY_W] = retry;
        w[STAT_LINK_UP_BIT]               = up;
        w[STAT_FAIL_BIT]                  = fl;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/olink_pulse_gen.sv
// ============================================================================
// Module  : olink_pulse_gen
// Purpose : Registered fixed-length pulse generator; o_last marks the final
//           high cycle so the owner can leave its state on the same edge.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module olink_pulse_gen #(
    parameter int LEN = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_abort,
    output logic o_pulse,
    output logic o_last
);

    localparam logic [7:0] C_LOAD = 8'(LEN - 1);

    logic       r_pulse;
    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pulse <= 1'b0;
            r_cnt   <= 8'd0;
        end else if (i_start) begin
            r_pulse <= 1'b1;
            r_cnt   <= C_LOAD;
        end else if (i_abort) begin
            r_pulse <= 1'b0;
            r_cnt   <= 8'd0;
        end else if (r_pulse) begin
            if (r_cnt == 8'd0) begin
                r_pulse <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    assign o_pulse = r_pulse;
    assign o_last  = r_pulse && (r_cnt == 8'd0);

endmodule

`default_nettype wire

// File: rtl/olink_bringup_ctrl.sv
// ============================================================================
// Module  : olink_bringup_ctrl
// Purpose : Optical link bring-up sequencer: PLL wait, TX/RX soft reset,
//           comma alignment, link watch, with timeout/bad-data retries.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module olink_bringup_ctrl
    import olink_pkg::*;
#(
    parameter int RST_PULSE = DEF_RST_PULSE,
    parameter int TMO_W     = DEF_TMO_W,
    parameter int COMMA_REQ = DEF_COMMA_REQ,
    parameter int BAD_LIMIT = DEF_BAD_LIMIT,
    parameter int MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic       clk_125,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       restart,
    input  logic       qpll_lock,
    input  logic       clk_link_lock,
    input  logic       tx_fsm_done,
    input  logic       rx_fsm_done,
    input  logic       link_ok,
    input  logic       comma_seen,
    output logic       soft_reset_tx,
    output logic       soft_reset_rx,
    output logic       link_up,
    output logic [2:0] state,
    output logic [3:0] retry_cnt,
    output logic       fail
);

    // Fires on the edge the counter would reach all-ones, so every wait
    // state lasts exactly 2^TMO_W-1 cycles before the retry.
    localparam logic [TMO_W-1:0] C_TMO_LAST   = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [7:0]       C_COMMA_LAST = 8'(COMMA_REQ - 1);
    localparam logic [7:0]       C_BAD_LAST   = 8'(BAD_LIMIT - 1);
    localparam logic [3:0]       C_MAX_RETRY  = 4'(MAX_RETRY);

    olink_state_e     r_state;
    logic [TMO_W-1:0] r_tmo;
    logic [7:0]       r_comma;
    logic [7:0]       r_bad;
    logic [3:0]       r_retry;
    logic             r_link_up;
    logic             r_fail;

    olink_state_e     w_next;
    olink_state_e     w_retry_tgt;
    logic             w_retry_evt;
    logic             w_lock;
    logic             w_timed;
    logic             w_tmo_hit;
    logic             w_tx_last;
    logic             w_rx_last;
    logic             w_changed;

    assign w_lock    = qpll_lock && clk_link_lock;
    assign w_timed   = (r_state == ST_WAIT_PLL) || (r_state == ST_WAIT_TX) ||
                       (r_state == ST_WAIT_RX)  || (r_state == ST_ALIGN);
    assign w_tmo_hit = w_timed && (r_tmo == C_TMO_LAST);
    assign w_changed = (w_next != r_state);

    always_comb begin
        w_next      = r_state;
        w_retry_evt = 1'b0;
        w_retry_tgt = ST_TX_RST;
        if (!enable) begin
            w_next = ST_IDLE;
        end else if (!w_lock && (r_state != ST_IDLE) && (r_state != ST_WAIT_PLL) &&
                     (r_state != ST_FAIL)) begin
            w_next = ST_WAIT_PLL;
        end else begin
            case (r_state)
                ST_IDLE:     w_next = ST_WAIT_PLL;
                ST_WAIT_PLL: begin
                    if (w_lock)         w_next = ST_TX_RST;
                    else if (w_tmo_hit) w_retry_evt = 1'b1;
                end
                ST_TX_RST:   if (w_tx_last) w_next = ST_WAIT_TX;
                ST_WAIT_TX: begin
                    if (tx_fsm_done)    w_next = ST_RX_RST;
                    else if (w_tmo_hit) w_retry_evt = 1'b1;
                end
                ST_RX_RST:   if (w_rx_last) w_next = ST_WAIT_RX;
                ST_WAIT_RX: begin
                    if (rx_fsm_done) begin
                        w_next = ST_ALIGN;
                    end else if (w_tmo_hit) begin
                        w_retry_evt = 1'b1;
                        w_retry_tgt = ST_RX_RST;
                    end
                end
                ST_ALIGN: begin
                    if (link_ok && comma_seen && (r_comma == C_COMMA_LAST)) w_next = ST_UP;
                    else if (w_tmo_hit) w_retry_evt = 1'b1;
                end
                ST_UP: begin
                    if (restart) begin
                        w_next = ST_TX_RST;
                    end else if (!link_ok && (r_bad == C_BAD_LAST)) begin
                        w_retry_evt = 1'b1;
                        w_retry_tgt = ST_RX_RST;
                    end
                end
                ST_FAIL:     if (restart) w_next = ST_TX_RST;
                default:     w_next = ST_IDLE;
            endcase
            if (w_retry_evt) begin
                w_next = (r_retry == C_MAX_RETRY) ? ST_FAIL : w_retry_tgt;
            end
        end
    end

    always_ff @(posedge clk_125) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_tmo     <= '0;
            r_comma   <= 8'd0;
            r_bad     <= 8'd0;
            r_retry   <= 4'd0;
            r_link_up <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_link_up <= (w_next == ST_UP);
            r_fail    <= (w_next == ST_FAIL);

            if (w_changed || !w_timed) r_tmo <= '0;
            else                       r_tmo <= r_tmo + 1'b1;

            if (w_changed || (r_state != ST_ALIGN) || !link_ok) r_comma <= 8'd0;
            else if (comma_seen)                               r_comma <= r_comma + 8'd1;

            if (w_changed || (r_state != ST_UP) || link_ok) r_bad <= 8'd0;
            else                                            r_bad <= r_bad + 8'd1;

            if (!enable) begin
                r_retry <= 4'd0;
            end else if ((w_next == ST_UP) && (r_state != ST_UP)) begin
                r_retry <= 4'd0;
            end else if ((r_state == ST_FAIL) && (w_next == ST_TX_RST)) begin
                r_retry <= 4'd0;
            end else if (w_retry_evt && (w_next != ST_FAIL) && (r_retry != 4'hF)) begin
                r_retry <= r_retry + 4'd1;
            end
        end
    end

    olink_pulse_gen #(.LEN(RST_PULSE)) u_tx_pulse (
        .clk     (clk_125),
        .rst_n   (reset_n),
        .i_start ((w_next == ST_TX_RST) && (r_state != ST_TX_RST)),
        .i_abort (w_next != ST_TX_RST),
        .o_pulse (soft_reset_tx),
        .o_last  (w_tx_last)
    );

    olink_pulse_gen #(.LEN(RST_PULSE)) u_rx_pulse (
        .clk     (clk_125),
        .rst_n   (reset_n),
        .i_start ((w_next == ST_RX_RST) && (r_state != ST_RX_RST)),
        .i_abort (w_next != ST_RX_RST),
        .o_pulse (soft_reset_rx),
        .o_last  (w_rx_last)
    );

    assign state     = r_state[2:0];
    assign retry_cnt = r_retry;
    assign link_up   = r_link_up;
    assign fail      = r_fail;

endmodule

`default_nettype wire

// File: tb/tb_olink_bringup_ctrl.sv
// ============================================================================
// Module  : tb_olink_bringup_ctrl
// Purpose : Directed self-checking bench for olink_bringup_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_olink_bringup_ctrl;

    logic       clk_125 = 1'b0;
    logic       reset_n, enable, restart, qpll_lock, clk_link_lock;
    logic       tx_fsm_done, rx_fsm_done, link_ok, comma_seen;
    logic       soft_reset_tx, soft_reset_rx, link_up, fail;
    logic [2:0] state;
    logic [3:0] retry_cnt;

    int total = 0;
    int bad   = 0;
    int n;
    int overlap;

    always #5 clk_125 = ~clk_125;

    olink_bringup_ctrl #(
        .RST_PULSE (4),
        .TMO_W     (6),
        .COMMA_REQ (3),
        .BAD_LIMIT (4),
        .MAX_RETRY (2)
    ) dut (
        .clk_125       (clk_125),
        .reset_n       (reset_n),
        .enable        (enable),
        .restart       (restart),
        .qpll_lock     (qpll_lock),
        .clk_link_lock (clk_link_lock),
        .tx_fsm_done   (tx_fsm_done),
        .rx_fsm_done   (rx_fsm_done),
        .link_ok       (link_ok),
        .comma_seen    (comma_seen),
        .soft_reset_tx (soft_reset_tx),
        .soft_reset_rx (soft_reset_rx),
        .link_up       (link_up),
        .state         (state),
        .retry_cnt     (retry_cnt),
        .fail          (fail)
    );

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk_125);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_comma();
        comma_seen = 1'b0;
        step(3);
        comma_seen = 1'b1;
        step(1);
        comma_seen = 1'b0;
    endtask

    task automatic measure_tx();
        n = 0;
        overlap = 0;
        while (soft_reset_tx === 1'b1 && n < 20) begin
            if (soft_reset_rx !== 1'b0) overlap++;
            n++;
            step(1);
        end
    endtask

    task automatic measure_rx();
        n = 0;
        overlap = 0;
        while (soft_reset_rx === 1'b1 && n < 20) begin
            if (soft_reset_tx !== 1'b0) overlap++;
            n++;
            step(1);
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; restart = 1'b0;
        qpll_lock = 1'b0; clk_link_lock = 1'b0;
        tx_fsm_done = 1'b0; rx_fsm_done = 1'b0;
        link_ok = 1'b1; comma_seen = 1'b0;
        step(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_tx", 32'(soft_reset_tx), 32'd0);
        chk("rst_rx", 32'(soft_reset_rx), 32'd0);
        chk("rst_up", 32'(link_up), 32'd0);
        chk("rst_retry", 32'(retry_cnt), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);

        // Normal bring-up
        reset_n = 1'b1; enable = 1'b1;
        step(1);
        chk("wait_pll", 32'(state), 32'd1);
        step(3);
        chk("wait_pll_hold", 32'(state), 32'd1);
        qpll_lock = 1'b1; clk_link_lock = 1'b1;
        step(1);
        chk("tx_rst_entry", 32'(state), 32'd2);
        measure_tx();
        chk("tx_pulse_len", 32'(n), 32'd4);
        chk("tx_rx_overlap", 32'(overlap), 32'd0);
        chk("wait_tx", 32'(state), 32'd3);
        step(9);
        chk("wait_tx_hold", 32'(state), 32'd3);
        tx_fsm_done = 1'b1;
        step(1);
        tx_fsm_done = 1'b0;
        chk("rx_rst_entry", 32'(state), 32'd4);
        measure_rx();
        chk("rx_pulse_len", 32'(n), 32'd4);
        chk("rx_tx_overlap", 32'(overlap), 32'd0);
        chk("wait_rx", 32'(state), 32'd5);
        step(9);
        rx_fsm_done = 1'b1;
        step(1);
        rx_fsm_done = 1'b0;
        chk("align_entry", 32'(state), 32'd6);
        send_comma();
        send_comma();
        chk("align_2commas_up", 32'(link_up), 32'd0);
        chk("align_2commas_st", 32'(state), 32'd6);
        send_comma();
        chk("up_link", 32'(link_up), 32'd1);
        chk("up_state", 32'(state), 32'd7);
        chk("up_fail", 32'(fail), 32'd0);

        // Bad data: 3 low cycles tolerated, 4 force an RX-only retry
        link_ok = 1'b0;
        step(3);
        link_ok = 1'b1;
        step(1);
        chk("bad3_up", 32'(link_up), 32'd1);
        chk("bad3_state", 32'(state), 32'd7);
        link_ok = 1'b0;
        step(4);
        link_ok = 1'b1;
        chk("bad4_state", 32'(state), 32'd4);
        chk("bad4_retry", 32'(retry_cnt), 32'd1);
        chk("bad4_tx", 32'(soft_reset_tx), 32'd0);
        chk("bad4_rx", 32'(soft_reset_rx), 32'd1);
        chk("bad4_up", 32'(link_up), 32'd0);

        // Lock loss in WAIT_RX
        step(4);
        chk("bad4_wait_rx", 32'(state), 32'd5);
        clk_link_lock = 1'b0;
        step(1);
        chk("lockloss_state", 32'(state), 32'd1);
        chk("lockloss_retry", 32'(retry_cnt), 32'd1);
        clk_link_lock = 1'b1; tx_fsm_done = 1'b1; rx_fsm_done = 1'b1;
        step(1);
        chk("relock_tx_rst", 32'(state), 32'd2);
        step(10);
        chk("relock_align", 32'(state), 32'd6);
        tx_fsm_done = 1'b0; rx_fsm_done = 1'b0;

        // Alignment broken by one link_ok-low cycle
        send_comma();
        send_comma();
        link_ok = 1'b0;
        step(1);
        link_ok = 1'b1;
        send_comma();
        chk("abreak_c1", 32'(link_up), 32'd0);
        send_comma();
        chk("abreak_c2", 32'(link_up), 32'd0);
        chk("abreak_c2_st", 32'(state), 32'd6);
        send_comma();
        chk("abreak_c3", 32'(link_up), 32'd1);
        chk("abreak_retry_clr", 32'(retry_cnt), 32'd0);

        // enable low in UP, then reset during a TX pulse
        enable = 1'b0;
        step(1);
        chk("dis_up", 32'(link_up), 32'd0);
        chk("dis_state", 32'(state), 32'd0);
        enable = 1'b1;
        step(2);
        chk("reen_tx_rst", 32'(state), 32'd2);
        chk("reen_tx", 32'(soft_reset_tx), 32'd1);
        step(1);
        reset_n = 1'b0;
        step(1);
        chk("midrst_tx", 32'(soft_reset_tx), 32'd0);
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_rx", 32'(soft_reset_rx), 32'd0);
        chk("midrst_up", 32'(link_up), 32'd0);
        chk("midrst_fail", 32'(fail), 32'd0);
        chk("midrst_retry", 32'(retry_cnt), 32'd0);

        // TX timeout, retries, FAIL, restart
        reset_n = 1'b1;
        step(2);
        chk("tmo_tx0", 32'(soft_reset_tx), 32'd1);
        step(66);
        chk("tmo_wait1", 32'(state), 32'd3);
        step(1);
        chk("tmo_tx1", 32'(soft_reset_tx), 32'd1);
        chk("tmo_retry1", 32'(retry_cnt), 32'd1);
        step(66);
        chk("tmo_wait2", 32'(state), 32'd3);
        step(1);
        chk("tmo_tx2", 32'(soft_reset_tx), 32'd1);
        chk("tmo_retry2", 32'(retry_cnt), 32'd2);
        step(66);
        chk("tmo_wait3", 32'(state), 32'd3);
        step(1);
        chk("fail_state", 32'(state), 32'd7);
        chk("fail_flag", 32'(fail), 32'd1);
        chk("fail_up", 32'(link_up), 32'd0);
        chk("fail_tx", 32'(soft_reset_tx), 32'd0);
        step(5);
        chk("fail_hold", 32'(fail), 32'd1);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk("restart_state", 32'(state), 32'd2);
        chk("restart_retry", 32'(retry_cnt), 32'd0);
        chk("restart_fail", 32'(fail), 32'd0);
        chk("restart_tx", 32'(soft_reset_tx), 32'd1);

        enable = 1'b0;
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
